// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC generation, in-order imem fetch with a
// credit-limited tag FIFO, an instruction buffer, and stall/flush/redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic [5:0]  op_d,
    output logic [5:0]  funct_d
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    function automatic ptr_t ptr_next(input ptr_t p);
        if (p == ptr_t'(DEPTH - 1)) return '0;
        return p + ptr_t'(1);
    endfunction

    logic [31:0] pc_q, pc_d;
    cnt_t        out_q, out_d;
    cnt_t        buf_count_q, buf_count_d;
    cnt_t        drop_q, drop_d;
    ptr_t        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    ptr_t        head_q, head_d, tail_q, tail_d;
    logic [31:0] tag_mem_q   [DEPTH];
    logic [31:0] tag_mem_d   [DEPTH];
    logic [31:0] buf_instr_q [DEPTH];
    logic [31:0] buf_instr_d [DEPTH];
    logic [31:0] buf_tag_q   [DEPTH];
    logic [31:0] buf_tag_d   [DEPTH];
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pcplus4_q, if_pcplus4_d;

    logic        load, pop, req_fire, rsp_fire, keep;
    logic [CW:0] credit_used;

    // A buffer pop in this cycle frees its credit immediately, sustaining 1 instr/cycle.
    always_comb begin
        load           = !flush_d && !stall_d;
        pop            = load && (buf_count_q != '0);
        credit_used    = {1'b0, out_q} + {1'b0, buf_count_q} - {{CW{1'b0}}, pop};
        imem_req_valid = reset_n && !redirect_valid && (credit_used < DEPTH_C);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_fire       = imem_rsp_valid && (out_q != '0);
        keep           = rsp_fire && (drop_q == '0) && !redirect_valid;
    end

    always_comb begin
        pc_d         = pc_q;
        out_d        = out_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);
        drop_d       = drop_q;
        tag_rd_d     = tag_rd_q;
        tag_wr_d     = tag_wr_q;
        tag_mem_d    = tag_mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        buf_instr_d  = buf_instr_q;
        buf_tag_d    = buf_tag_q;
        buf_count_d  = buf_count_q + cnt_t'(keep) - cnt_t'(pop);
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pcplus4_d = if_pcplus4_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        if (req_fire) begin
            tag_mem_d[tag_wr_q] = pc_q + 32'd4;
            tag_wr_d            = ptr_next(tag_wr_q);
        end
        if (rsp_fire) begin
            tag_rd_d = ptr_next(tag_rd_q);
        end

        if (keep) begin
            buf_instr_d[tail_q] = imem_rsp_data;
            buf_tag_d[tail_q]   = tag_mem_q[tag_rd_q];
            tail_d              = ptr_next(tail_q);
        end
        if (pop) begin
            head_d = ptr_next(head_q);
        end

        // Everything still in flight after this cycle's response belongs to the old path.
        if (redirect_valid) begin
            drop_d      = out_q - cnt_t'(rsp_fire);
            head_d      = tail_q;
            buf_count_d = '0;
        end else if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - cnt_t'(1);
        end

        if (flush_d) begin
            if_valid_d = 1'b0;
            if_instr_d = '0;
        end else if (load) begin
            if (buf_count_q != '0) begin
                if_valid_d   = 1'b1;
                if_instr_d   = buf_instr_q[head_q];
                if_pcplus4_d = buf_tag_q[head_q];
            end else begin
                if_valid_d = 1'b0;
                if_instr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            out_q        <= '0;
            buf_count_q  <= '0;
            drop_q       <= '0;
            tag_rd_q     <= '0;
            tag_wr_q     <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            tag_mem_q    <= '{default: '0};
            buf_instr_q  <= '{default: '0};
            buf_tag_q    <= '{default: '0};
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pcplus4_q <= '0;
        end else begin
            pc_q         <= pc_d;
            out_q        <= out_d;
            buf_count_q  <= buf_count_d;
            drop_q       <= drop_d;
            tag_rd_q     <= tag_rd_d;
            tag_wr_q     <= tag_wr_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            tag_mem_q    <= tag_mem_d;
            buf_instr_q  <= buf_instr_d;
            buf_tag_q    <= buf_tag_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pcplus4_q <= if_pcplus4_d;
        end
    end

    assign valid_d   = if_valid_q;
    assign instr_d   = if_instr_q;
    assign pcplus4_d = if_pcplus4_q;
    assign op_d      = if_instr_q[31:26];
    assign funct_d   = if_instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an in-order imem model with configurable latency
// feeds the DUT while each scenario task checks the IF/ID outputs inline.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_d, flush_d, redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_d;
    logic [31:0] instr_d, pcplus4_d;
    logic [5:0]  op_d, funct_d;

    logic        w_one    = 1'b1;
    logic        w_zero   = 1'b0;
    logic [31:0] w_zero32 = 32'h0;
    logic        w_req_valid, w_valid;
    logic [31:0] w_addr, w_instr, w_pc4;
    logic [5:0]  w_op, w_funct;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_pc4;
    logic [31:0] next_addr;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .stall_d(stall_d), .flush_d(flush_d),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .valid_d(valid_d), .instr_d(instr_d), .pcplus4_d(pcplus4_d),
        .op_d(op_d), .funct_d(funct_d)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_one),
        .imem_req_addr(w_addr), .imem_rsp_valid(w_zero),
        .imem_rsp_data(w_zero32), .stall_d(w_zero), .flush_d(w_zero),
        .redirect_valid(w_zero), .redirect_pc(w_zero32),
        .valid_d(w_valid), .instr_d(w_instr), .pcplus4_d(w_pc4),
        .op_d(w_op), .funct_d(w_funct)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C08_0004;
        if (a == 32'h4) return 32'h2109_000C;
        return 32'hA000_0000 | a;
    endfunction

    // One clock: sample handshakes before the edge, update the imem model after it.
    task automatic tick();
        logic        fire_now;
        logic        rsp_now;
        logic [31:0] addr_now;
        #1;
        fire_now = imem_req_valid && imem_req_ready;
        addr_now = imem_req_addr;
        rsp_now  = imem_rsp_valid;
        @(posedge clk);
        cyc++;
        if (rsp_now && pend_addr.size() > 0) begin
            pend_addr.delete(0);
            pend_due.delete(0);
        end
        if (fire_now) begin
            pend_addr.push_back(addr_now);
            pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)) - 1);
            next_addr = addr_now + 32'd4;
        end
        #1;
        if (pend_addr.size() > 0 && cyc >= pend_due[0]) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_d); end
        total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr_d); end
        total++; if (pcplus4_d !== 32'h0) begin bad++; $display("FAIL reset_pc4: got %h want 0", pcplus4_d); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        reset_n = 1'b1;
        exp_pc4 = 32'h4;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL stream_latency[%0d]: got %b want 0", i, valid_d); end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (valid_d !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, valid_d); end
            total++; if (pcplus4_d !== exp_pc4) begin bad++; $display("FAIL stream_pc4[%0d]: got %h want %h", i, pcplus4_d, exp_pc4); end
            total++; if (instr_d !== mem_word(exp_pc4 - 32'd4)) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr_d, mem_word(exp_pc4 - 32'd4)); end
            if (i == 0) begin
                total++; if (op_d !== 6'b100011) begin bad++; $display("FAIL stream_op0: got %b want 100011", op_d); end
            end
            if (i == 1) begin
                total++; if (op_d !== 6'b001000) begin bad++; $display("FAIL stream_op1: got %b want 001000", op_d); end
                total++; if (funct_d !== 6'b001100) begin bad++; $display("FAIL stream_funct1: got %b want 001100", funct_d); end
            end
            exp_pc4 += 32'd4;
        end
    endtask

    task automatic test_stall();
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pcplus4_d !== exp_pc4 - 32'd4) begin bad++; $display("FAIL stall_pc4[%0d]: got %h want %h", i, pcplus4_d, exp_pc4 - 32'd4); end
            total++; if (instr_d !== mem_word(exp_pc4 - 32'd8)) begin bad++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr_d, mem_word(exp_pc4 - 32'd8)); end
            #1;
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_credit[%0d]: got %b want 0", i, imem_req_valid); end
        end
        stall_d = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (valid_d !== 1'b1) begin bad++; $display("FAIL unstall_valid[%0d]: got %b want 1", i, valid_d); end
            total++; if (pcplus4_d !== exp_pc4) begin bad++; $display("FAIL unstall_pc4[%0d]: got %h want %h", i, pcplus4_d, exp_pc4); end
            exp_pc4 += 32'd4;
        end
    endtask

    task automatic test_redirect();
        bit found;
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pend_addr.size() == 2) found = 1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL redirect_setup: in-flight count never reached 2"); end
        lat_min = 1; lat_max = 1;
        flush_d = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redirect_no_req: got %b want 0", imem_req_valid); end
        tick();
        flush_d = 1'b0; redirect_valid = 1'b0;
        total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL redirect_flush_valid: got %b want 0", valid_d); end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (valid_d === 1'b1) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL redirect_timeout: no valid_d after redirect"); end
        total++; if (pcplus4_d !== 32'h44) begin bad++; $display("FAIL redirect_pc4: got %h want 00000044", pcplus4_d); end
        total++; if (instr_d !== 32'hA000_0040) begin bad++; $display("FAIL redirect_instr: got %h want a0000040", instr_d); end
        exp_pc4 = 32'h48;
    endtask

    task automatic test_flush_stall();
        bit found;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid_d === 1'b1) begin
                total++; if (pcplus4_d !== exp_pc4) begin bad++; $display("FAIL pre_flush_pc4[%0d]: got %h want %h", i, pcplus4_d, exp_pc4); end
                exp_pc4 += 32'd4;
            end
        end
        stall_d = 1'b1; flush_d = 1'b1;
        tick();
        stall_d = 1'b0; flush_d = 1'b0;
        total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL flush_wins_valid: got %b want 0", valid_d); end
        total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL flush_wins_instr: got %h want 0", instr_d); end
        total++; if (pcplus4_d !== exp_pc4 - 32'd4) begin bad++; $display("FAIL flush_wins_pc4: got %h want %h", pcplus4_d, exp_pc4 - 32'd4); end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (valid_d === 1'b1) found = 1;
        end
        total++; if (!found || pcplus4_d !== exp_pc4) begin bad++; $display("FAIL after_flush_pc4: got %h want %h", pcplus4_d, exp_pc4); end
        exp_pc4 += 32'd4;
    endtask

    task automatic test_back_to_back();
        bit found;
        flush_d = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_pc = 32'h0000_0200;
        tick();
        flush_d = 1'b0; redirect_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (valid_d === 1'b1) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL b2b_timeout: no valid_d after redirects"); end
        total++; if (pcplus4_d !== 32'h204) begin bad++; $display("FAIL b2b_pc4: got %h want 00000204", pcplus4_d); end
        total++; if (instr_d !== 32'hA000_0200) begin bad++; $display("FAIL b2b_instr: got %h want a0000200", instr_d); end
        exp_pc4 = 32'h208;
    endtask

    task automatic test_random();
        int delivered;
        int undelivered;
        delivered = 0;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 200; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            tick();
            if (valid_d === 1'b1) begin
                total++; if (pcplus4_d !== exp_pc4) begin bad++; $display("FAIL random_pc4[%0d]: got %h want %h", i, pcplus4_d, exp_pc4); end
                total++; if (instr_d !== mem_word(exp_pc4 - 32'd4)) begin bad++; $display("FAIL random_instr[%0d]: got %h want %h", i, instr_d, mem_word(exp_pc4 - 32'd4)); end
                exp_pc4 += 32'd4;
                delivered++;
            end
            undelivered = int'((next_addr - (exp_pc4 - 32'd4)) >> 2);
            total++; if (undelivered > 2 || pend_addr.size() > 2) begin bad++; $display("FAIL random_credit[%0d]: got %0d in flight+buffered want <= 2", i, undelivered); end
        end
        total++; if (delivered < 20) begin bad++; $display("FAIL random_progress: got %0d delivered want >= 20", delivered); end
        imem_req_ready = 1'b1;
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_reset_midstream();
        bit found;
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pend_addr.size() == 2) found = 1;
            else tick();
        end
        total++; if (!found) begin bad++; $display("FAIL midreset_setup: in-flight count never reached 2"); end
        lat_min = 1; lat_max = 1;
        reset_n = 1'b0;
        #1;
        total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", valid_d); end
        total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL midreset_instr: got %h want 0", instr_d); end
        total++; if (pcplus4_d !== 32'h0) begin bad++; $display("FAIL midreset_pc4: got %h want 0", pcplus4_d); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL midreset_req_valid: got %b want 0", imem_req_valid); end
        pend_addr.delete();
        pend_due.delete();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL midreset_addr: got %h want 0", imem_req_addr); end
        total++; if (w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_reset_addr: got %h want fffffffc", w_addr); end
        total++; if (w_req_valid !== 1'b1) begin bad++; $display("FAIL wrap_req_valid: got %b want 1", w_req_valid); end
        tick();
        total++; if (w_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr: got %h want 0", w_addr); end
        exp_pc4 = 32'h4;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (valid_d === 1'b1) found = 1;
        end
        total++; if (!found || pcplus4_d !== 32'h4) begin bad++; $display("FAIL midreset_resume_pc4: got %h want 00000004", pcplus4_d); end
        total++; if (instr_d !== 32'h8C08_0004) begin bad++; $display("FAIL midreset_resume_instr: got %h want 8c080004", instr_d); end
    endtask

    initial begin
        reset_n        = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        stall_d        = 1'b0;
        flush_d        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        next_addr      = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_flush_stall();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
